keypad_scan_ctrl: RTL and testbench

Scan controller for the 4x4 matrix keypad on the MAX1000 keypad-decoder Nios project. It runs the 12 MHz-to-scan-rate prescaler and drives the column strobes one at a time. It samples and debounces the rows and hands single key codes to the Nios PIO through a valid/ready handshake. It replaces the free-running divider with a sequenced tick and scan engine.

---
 rtl/keypad_pkg.sv | 58 +++++
 rtl/keypad_scan_ctrl_if.sv | 26 ++
 rtl/keypad_scan_ctrl_tick_gen.sv | 34 +++
 rtl/keypad_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the 4x4 keypad scan controller.
//   - NUM_COLS / NUM_ROWS / NUM_KEYS : matrix geometry
//   - key_t       : 4-bit key code, col*4 + row
//   - state_e     : scan FSM states (IDLE, SCAN)
//   - cls_e       : frame classification (NONE, ONE, MULTI)
//   - frame_cls_t : classification plus key index (key is 0 unless ONE)
//   - classify()  : reduces a 16-bit frame snapshot to a frame_cls_t
package keypad_pkg;

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_KEYS = NUM_COLS * NUM_ROWS;

    typedef logic [3:0] key_t;

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    typedef enum logic [1:0] {
        NONE,
        ONE,
        MULTI
    } cls_e;

    typedef struct packed {
        cls_e cls;
        key_t key;
    } frame_cls_t;

    // key is forced to 0 for NONE/MULTI so that whole-struct equality
    // compares only what matters for debouncing.
    function automatic frame_cls_t classify(input logic [NUM_KEYS-1:0] snap);
        frame_cls_t  r;
        int unsigned n;
        r.cls = NONE;
        r.key = '0;
        n     = 0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (snap[i]) begin
                n++;
                r.key = key_t'(i);
            end
        end
        if (n == 1) begin
            r.cls = ONE;
        end else if (n > 1) begin
            r.cls = MULTI;
        end
        if (r.cls != ONE) begin
            r.key = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if
//   Key hand-off between the scan controller and the Nios PIO.
//   - key_code  : accepted key (col*4 + row), driven by master
//   - key_valid : key_code holds an unread key, driven by master
//   - key_ready : consumer accepts key_code this cycle, driven by slave
//   A transfer occurs in any cycle with key_valid & key_ready.
interface keypad_scan_ctrl_if;
    import keypad_pkg::*;

    key_t key_code;
    logic key_valid;
    logic key_ready;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );

endinterface

// File: rtl/keypad_scan_ctrl_tick_gen.sv
// tick_gen
//   Scan-step prescaler. Counts 0..TICK_DIV-1 and wraps; tick is high for
//   the single cycle in which the count equals TICK_DIV-1.
//   - clk     : system clock
//   - reset_b : asynchronous active-low reset
//   - clr     : synchronous hold of the count at 0
//   - tick    : one-cycle step strobe
module tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_b,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt_q <= '0;
        end else if (clr || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   4x4 matrix keypad scanner: strobes one column at a time (active-low),
//   samples the synchronized rows on each scan tick, debounces whole
//   frames and hands single key codes out over a valid/ready handshake.
//   - clk_12m_in  : 12 MHz system clock
//   - reset_b     : asynchronous active-low reset
//   - scan_en     : 1 = scanning, 0 = idle
//   - row_n       : keypad rows, active-low, asynchronous
//   - col_n       : column drive, active-low, one-hot-low while scanning
//   - overrun     : sticky, a key was accepted while key_valid was pending
//   - overrun_clr : clears overrun (a simultaneous set wins)
//   - kbus        : key_code / key_valid / key_ready handshake (master)
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic                clk_12m_in,
    input  logic                reset_b,
    input  logic                scan_en,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic                overrun,
    input  logic                overrun_clr,
    keypad_scan_ctrl_if.master  kbus
);

    localparam logic [3:0] DB_CNT = 4'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0] row_meta_q;
    logic [NUM_ROWS-1:0] row_sync_q;
    logic [NUM_ROWS-1:0] rows_act;

    state_e              state_q;
    logic [1:0]          col_q;
    logic [1:0]          col_d;
    logic [NUM_COLS-1:0] col_n_q;
    logic [NUM_KEYS-1:0] snap_q;
    frame_cls_t          cand_q;
    logic [3:0]          dcnt_q;
    logic [3:0]          dcnt_d;
    logic                armed_q;
    key_t                key_code_q;
    logic                key_valid_q;
    logic                overrun_q;

    logic                tick;
    logic                tick_clr;
    frame_cls_t          frame_cls;
    logic                qualified;
    logic                frame_end;
    logic                accept;
    logic                release_ok;
    logic                xfer;

    always_ff @(posedge clk_12m_in or negedge reset_b) begin
        if (!reset_b) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
        end
    end

    assign rows_act = ~row_sync_q;

    // Clearing on !scan_en as well makes the counter read 0 on the first
    // IDLE cycle, not just from the second one on.
    assign tick_clr = (state_q == IDLE) || !scan_en;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk     (clk_12m_in),
        .reset_b (reset_b),
        .clr     (tick_clr),
        .tick    (tick)
    );

    always_comb begin
        col_d = col_q + 2'd1;
        // Column 3 rows are taken live so the frame is classified on the
        // same tick that samples them.
        frame_cls = classify({rows_act, snap_q[11:0]});
        if (frame_cls != cand_q) begin
            dcnt_d = 4'd1;
        end else if (dcnt_q == DB_CNT) begin
            dcnt_d = dcnt_q;
        end else begin
            dcnt_d = dcnt_q + 4'd1;
        end
        qualified  = (dcnt_d == DB_CNT);
        frame_end  = (state_q == SCAN) && scan_en && tick && (col_q == 2'd3);
        accept     = frame_end && qualified && (frame_cls.cls == ONE) && armed_q;
        release_ok = frame_end && qualified && (frame_cls.cls == NONE);
        xfer       = key_valid_q && kbus.key_ready;
    end

    always_ff @(posedge clk_12m_in or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= IDLE;
            col_q       <= '0;
            col_n_q     <= '1;
            snap_q      <= '0;
            cand_q      <= '{cls: NONE, key: '0};
            dcnt_q      <= '0;
            armed_q     <= 1'b1;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan_en) begin
                        state_q <= SCAN;
                        col_q   <= '0;
                        col_n_q <= 4'hE;
                    end
                end
                SCAN: begin
                    if (!scan_en) begin
                        state_q <= IDLE;
                        col_q   <= '0;
                        col_n_q <= '1;
                        snap_q  <= '0;
                        cand_q  <= '{cls: NONE, key: '0};
                        dcnt_q  <= '0;
                        armed_q <= 1'b1;
                    end else if (tick) begin
                        snap_q[{col_q, 2'b00} +: NUM_ROWS] <= rows_act;
                        col_q   <= col_d;
                        col_n_q <= ~(4'b0001 << col_d);
                        if (col_q == 2'd3) begin
                            cand_q <= frame_cls;
                            dcnt_q <= dcnt_d;
                            if (accept) begin
                                armed_q <= 1'b0;
                            end else if (release_ok) begin
                                armed_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    col_n_q <= '1;
                end
            endcase

            if (accept && (!key_valid_q || xfer)) begin
                key_code_q  <= frame_cls.key;
                key_valid_q <= 1'b1;
            end else if (xfer) begin
                key_valid_q <= 1'b0;
            end

            if (accept && key_valid_q && !xfer) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign col_n          = col_n_q;
    assign overrun        = overrun_q;
    assign kbus.key_code  = key_code_q;
    assign kbus.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
//   Drives an ideal 4x4 key matrix from a 16-bit "pressed" set and compares
//   the controller against a frame-level reference model that keeps the
//   history of frame classes and applies the accept/release/handshake rules.
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    localparam int unsigned TD = 4;
    localparam int unsigned DB = 2;

    logic       clk_12m_in = 1'b0;
    logic       reset_b;
    logic       scan_en;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       overrun;
    logic       overrun_clr;
    logic [15:0] pressed;

    keypad_scan_ctrl_if kb ();

    keypad_scan_ctrl #(
        .TICK_DIV       (TD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk_12m_in  (clk_12m_in),
        .reset_b     (reset_b),
        .scan_en     (scan_en),
        .row_n       (row_n),
        .col_n       (col_n),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .kbus        (kb)
    );

    always #5 clk_12m_in = ~clk_12m_in;

    // A pressed key at col c / row r pulls row r low while col c is driven.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col_n[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[c*4 + r]) row_n[r] = 1'b0;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         hist[$];
    bit         m_armed;
    bit         m_valid;
    logic [3:0] m_code;
    bit         m_ovr;

    // -1 = no key, 0..15 = single key, 16 = several keys
    function automatic int class_of(input logic [15:0] k);
        int n;
        n = $countones(k);
        if (n == 0) return -1;
        if (n > 1) return 16;
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return -1;
    endfunction

    task automatic model_restart();
        hist.delete();
        m_armed = 1'b1;
    endtask

    task automatic model_frame(input logic [15:0] keys, input bit pop_early,
                               input bit ready_end, input bit clr_end);
        int c;
        int run;
        int acc;
        bit xfer;
        bit set_ovr;
        c = class_of(keys);
        hist.push_back(c);
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != c) break;
            run++;
        end
        acc = -1;
        if (run >= DB) begin
            if (c == -1) m_armed = 1'b1;
            else if (c < 16 && m_armed) begin
                acc = c;
                m_armed = 1'b0;
            end
        end
        if (pop_early && m_valid) m_valid = 1'b0;
        xfer    = ready_end && m_valid;
        set_ovr = (acc >= 0) && m_valid && !xfer;
        if (acc >= 0) begin
            if (!m_valid || xfer) begin
                m_code  = 4'(acc);
                m_valid = 1'b1;
            end
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        if (set_ovr) m_ovr = 1'b1;
        else if (clr_end) m_ovr = 1'b0;
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".key_valid"}, 16'(kb.key_valid), 16'(m_valid));
        check({ctx, ".key_code"},  16'(kb.key_code),  16'(m_code));
        check({ctx, ".overrun"},   16'(overrun),      16'(m_ovr));
    endtask

    // ---------------- stimulus helpers ----------------
    // Called on the first negedge of a frame; returns on the first negedge
    // of the next frame, just after the frame-end edge.
    task automatic run_frame(input logic [15:0] keys, input bit pop_early,
                             input bit ready_end, input bit clr_end);
        logic [3:0] exp_col;
        pressed      = keys;
        kb.key_ready = pop_early;
        overrun_clr  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_col = ~(4'b0001 << (i / 4));
            check("col_n_scan", 16'(col_n), 16'(exp_col));
            if (i == 1) kb.key_ready = 1'b0;
            if (i == 15) begin
                kb.key_ready = ready_end;
                overrun_clr  = clr_end;
            end
            @(negedge clk_12m_in);
        end
        kb.key_ready = 1'b0;
        overrun_clr  = 1'b0;
        model_frame(keys, pop_early, ready_end, clr_end);
        check_outputs("frame");
    endtask

    task automatic start_scan();
        scan_en = 1'b1;
        @(negedge clk_12m_in);
        model_restart();
    endtask

    // Abandon a frame part-way, check idle, then restart scanning.
    task automatic stop_mid_frame(input logic [15:0] keys, input int unsigned k);
        pressed = keys;
        repeat (k) @(negedge clk_12m_in);
        scan_en = 1'b0;
        @(negedge clk_12m_in);
        check("col_n_stop", 16'(col_n), 16'hF);
        check_outputs("stop");
        repeat (5) begin
            @(negedge clk_12m_in);
            check("col_n_idle", 16'(col_n), 16'hF);
        end
        start_scan();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cur;
        logic [15:0] one16;
        int unsigned a;
        int unsigned b;
        int unsigned r;

        one16        = 16'h0001;
        reset_b      = 1'b0;
        scan_en      = 1'b0;
        overrun_clr  = 1'b0;
        kb.key_ready = 1'b0;
        pressed      = '0;
        m_valid      = 1'b0;
        m_code       = '0;
        m_ovr        = 1'b0;
        model_restart();

        // power-on reset and idle
        repeat (3) @(negedge clk_12m_in);
        check("rst.col_n", 16'(col_n), 16'hF);
        check_outputs("rst");
        reset_b = 1'b1;
        repeat (8) begin
            @(negedge clk_12m_in);
            check("idle.col_n", 16'(col_n), 16'hF);
        end

        // scan order with quiet frames
        start_scan();
        run_frame('0, 0, 0, 0);
        run_frame('0, 0, 0, 0);

        // single press of key 6, held three frames, nobody reading
        run_frame(16'h0040, 0, 0, 0);
        check("single.pre", 16'(kb.key_valid), 16'h0);
        run_frame(16'h0040, 0, 0, 0);
        check("single.valid", 16'(kb.key_valid), 16'h1);
        check("single.code",  16'(kb.key_code),  16'h6);
        run_frame(16'h0040, 0, 0, 0);
        check("single.no_repeat", 16'(overrun), 16'h0);

        // release two frames re-arms; second press of key 6 accepted
        run_frame('0, 1, 0, 0);
        run_frame('0, 0, 0, 0);
        run_frame(16'h0040, 0, 0, 0);
        run_frame(16'h0040, 0, 0, 0);
        check("rearm.valid", 16'(kb.key_valid), 16'h1);
        check("rearm.code",  16'(kb.key_code),  16'h6);

        // release for only one frame does not re-arm
        run_frame('0, 1, 0, 0);
        run_frame(16'h0040, 0, 0, 0);
        run_frame(16'h0040, 0, 0, 0);
        check("short_release.valid", 16'(kb.key_valid), 16'h0);

        // keys 0 and 5 together never qualify; releasing 5 accepts 0
        run_frame('0, 0, 0, 0);
        run_frame('0, 0, 0, 0);
        repeat (3) run_frame(16'h0021, 0, 0, 0);
        check("multi.valid", 16'(kb.key_valid), 16'h0);
        run_frame(16'h0001, 0, 0, 0);
        run_frame(16'h0001, 0, 0, 0);
        check("multi_rel.valid", 16'(kb.key_valid), 16'h1);
        check("multi_rel.code",  16'(kb.key_code),  16'h0);

        // overrun: key 3 pending, key 12 accepted on top
        run_frame('0, 1, 0, 0);
        run_frame('0, 0, 0, 0);
        run_frame(16'h0008, 0, 0, 0);
        run_frame(16'h0008, 0, 0, 0);
        run_frame('0, 0, 0, 0);
        run_frame('0, 0, 0, 0);
        run_frame(16'h1000, 0, 0, 0);
        run_frame(16'h1000, 0, 0, 0);
        check("ovr.code", 16'(kb.key_code), 16'h3);
        check("ovr.flag", 16'(overrun),     16'h1);

        // clear coinciding with a new overrun keeps the flag
        run_frame('0, 0, 0, 0);
        run_frame('0, 0, 0, 0);
        run_frame(16'h1000, 0, 0, 0);
        run_frame(16'h1000, 0, 0, 1);
        check("ovr_clr_set.flag", 16'(overrun), 16'h1);
        run_frame('0, 0, 0, 1);
        check("ovr_clr.flag", 16'(overrun), 16'h0);

        // accept in the same cycle as a transfer loads the new key
        run_frame('0, 0, 0, 0);
        run_frame(16'h0200, 0, 0, 0);
        run_frame(16'h0200, 0, 1, 0);
        check("accept_xfer.valid", 16'(kb.key_valid), 16'h1);
        check("accept_xfer.code",  16'(kb.key_code),  16'h9);

        // build up valid + overrun, then reset mid-frame
        run_frame('0, 0, 0, 0);
        run_frame('0, 0, 0, 0);
        run_frame(16'h0002, 0, 0, 0);
        run_frame(16'h0002, 0, 0, 0);
        repeat (6) @(negedge clk_12m_in);
        reset_b = 1'b0;
        #1;
        m_valid = 1'b0;
        m_code  = '0;
        m_ovr   = 1'b0;
        check("rst_mid.col_n", 16'(col_n), 16'hF);
        check_outputs("rst_mid");
        scan_en = 1'b0;
        @(negedge clk_12m_in);
        reset_b = 1'b1;
        repeat (10) begin
            @(negedge clk_12m_in);
            check("rst_idle.col_n", 16'(col_n), 16'hF);
        end
        start_scan();

        // stopping mid-frame discards the debounce progress
        run_frame(16'h0200, 0, 0, 0);
        stop_mid_frame(16'h0200, 7);
        run_frame(16'h0200, 0, 0, 0);
        check("stop.no_accept", 16'(kb.key_valid), 16'h0);
        run_frame(16'h0200, 0, 0, 0);

        // randomized frames
        cur = '0;
        for (int f = 0; f < 48; f++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                cur = cur;
            end else if (r < 6) begin
                cur = '0;
            end else if (r < 9) begin
                a   = $urandom_range(0, 15);
                cur = one16 << a;
            end else begin
                a   = $urandom_range(0, 15);
                b   = (a + 1 + $urandom_range(0, 14)) % 16;
                cur = (one16 << a) | (one16 << b);
            end
            if (f == 24) begin
                stop_mid_frame(cur, $urandom_range(1, 14));
            end
            run_frame(cur, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
